// File: rtl/pe_row_conv_param_if.sv
// Handshake bundle for pe_row_conv_param: row control, weight stream, activation stream, result stream.
// The block connects through the slave modport; the producer/consumer side uses master.
interface pe_row_conv_param_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 18
);
  logic                        start;
  logic                        load_w;
  logic                        w_valid;
  logic signed [WIDTH-1:0]     w_data;
  logic                        w_ready;
  logic                        i_valid;
  logic signed [WIDTH-1:0]     i_data;
  logic                        i_ready;
  logic                        o_valid;
  logic signed [ACC_WIDTH-1:0] o_psum;
  logic                        o_last;
  logic                        o_ready;
  logic                        busy;

  modport master (
    output start, load_w, w_valid, w_data, i_valid, i_data, o_ready,
    input  w_ready, i_ready, o_valid, o_psum, o_last, busy
  );

  modport slave (
    input  start, load_w, w_valid, w_data, i_valid, i_data, o_ready,
    output w_ready, i_ready, o_valid, o_psum, o_last, busy
  );
endinterface

// File: rtl/pe_row_conv_param.sv
// 1D conv row engine: loads K taps (optional), ROW_LEN activations, then emits one psum per K+1 cycles.
// First result K+1 cycles after the last activation; a stalled result holds the whole engine.
module pe_row_conv_param #(
  parameter int WIDTH     = 8,
  parameter int K         = 3,
  parameter int STRIDE    = 2,
  parameter int PAD       = 1,
  parameter int ROW_LEN   = 8,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(K)
) (
  input logic              clk,
  input logic              rstn,
  pe_row_conv_param_if.slave bus
);

  localparam int OUT_LEN = (ROW_LEN + 2*PAD - K) / STRIDE + 1;
  localparam int KW      = (K > 1)       ? $clog2(K)       : 1;
  localparam int XW      = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int JW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_X, S_COMPUTE, S_OUT
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_wvalid;
  logic [KW-1:0]               r_wc;
  logic [XW-1:0]               r_xc;
  logic [JW-1:0]               r_j;
  logic [KW-1:0]               r_k;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [WIDTH-1:0]     r_tap  [K];
  logic signed [WIDTH-1:0]     r_xbuf [ROW_LEN];

  int                          w_idx;
  logic                        w_in_row;
  logic [XW-1:0]               w_xsel;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0] w_term;
  logic                        w_last;
  logic                        w_tap_end;
  logic                        w_row_end;

  assign w_last    = (r_j  == JW'(OUT_LEN - 1));
  assign w_tap_end = (r_wc == KW'(K - 1));
  assign w_row_end = (r_xc == XW'(ROW_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = (bus.load_w || !r_wvalid) ? S_LOAD_W : S_LOAD_X;
      S_LOAD_W:  if (bus.w_valid && w_tap_end) w_next = S_LOAD_X;
      S_LOAD_X:  if (bus.i_valid && w_row_end) w_next = S_COMPUTE;
      S_COMPUTE: if (r_k == KW'(K - 1)) w_next = S_OUT;
      S_OUT:     if (bus.o_ready) w_next = w_last ? S_IDLE : S_COMPUTE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Taps outside the row are padding: the cycle is spent but contributes zero.
  always_comb begin
    w_idx    = int'(r_j) * STRIDE + int'(r_k) - PAD;
    w_in_row = (w_idx >= 0) && (w_idx < ROW_LEN);
    w_xsel   = w_in_row ? w_idx[XW-1:0] : '0;
    w_prod   = r_tap[r_k] * r_xbuf[w_xsel];
    w_term   = w_in_row ? ACC_WIDTH'(w_prod) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wvalid <= 1'b0;
      r_wc     <= '0;
      r_xc     <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_wc <= '0;
          r_xc <= '0;
        end
        S_LOAD_W: if (bus.w_valid) begin
          r_wc <= r_wc + 1'b1;
          if (w_tap_end) r_wvalid <= 1'b1;
        end
        S_LOAD_X: if (bus.i_valid) begin
          r_xc <= r_xc + 1'b1;
          if (w_row_end) begin
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        S_COMPUTE: begin
          r_acc <= r_acc + w_term;
          r_k   <= (r_k == KW'(K - 1)) ? '0 : r_k + 1'b1;
        end
        S_OUT: if (bus.o_ready && !w_last) begin
          r_j   <= r_j + 1'b1;
          r_k   <= '0;
          r_acc <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && r_state == S_LOAD_W && bus.w_valid) r_tap[r_wc]  <= bus.w_data;
    if (rstn && r_state == S_LOAD_X && bus.i_valid) r_xbuf[r_xc] <= bus.i_data;
  end

  assign bus.w_ready = (r_state == S_LOAD_W);
  assign bus.i_ready = (r_state == S_LOAD_X);
  assign bus.o_valid = (r_state == S_OUT);
  assign bus.o_psum  = (r_state == S_OUT) ? r_acc : '0;
  assign bus.o_last  = (r_state == S_OUT) && w_last;
  assign bus.busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_pe_row_conv_param.sv
// Directed bench: dut_a uses the default stride-2 row, dut_b the stride-1 variant.
// Row vectors come from a table; reset-mid-row is a hand-written sequence.
module tb_pe_row_conv_param;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_a, start_b, load_w, w_valid, i_valid, o_ready;
  logic [7:0] w_data, i_data;
  logic       sel;
  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;

  always #5 clk = ~clk;

  pe_row_conv_param_if #(.WIDTH(8), .ACC_WIDTH(18)) bus_a ();
  pe_row_conv_param_if #(.WIDTH(8), .ACC_WIDTH(18)) bus_b ();

  assign bus_a.start   = start_a;
  assign bus_b.start   = start_b;
  assign bus_a.load_w  = load_w;
  assign bus_b.load_w  = load_w;
  assign bus_a.w_valid = w_valid;
  assign bus_b.w_valid = w_valid;
  assign bus_a.w_data  = w_data;
  assign bus_b.w_data  = w_data;
  assign bus_a.i_valid = i_valid;
  assign bus_b.i_valid = i_valid;
  assign bus_a.i_data  = i_data;
  assign bus_b.i_data  = i_data;
  assign bus_a.o_ready = o_ready;
  assign bus_b.o_ready = o_ready;

  pe_row_conv_param #(.WIDTH(8), .K(3), .STRIDE(2), .PAD(1), .ROW_LEN(8)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a));
  pe_row_conv_param #(.WIDTH(8), .K(3), .STRIDE(1), .PAD(1), .ROW_LEN(8)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b));

  logic        w_ready_m, i_ready_m, o_valid_m, o_last_m, busy_m;
  logic [17:0] o_psum_m;
  assign w_ready_m = sel ? bus_b.w_ready : bus_a.w_ready;
  assign i_ready_m = sel ? bus_b.i_ready : bus_a.i_ready;
  assign o_valid_m = sel ? bus_b.o_valid : bus_a.o_valid;
  assign o_last_m  = sel ? bus_b.o_last  : bus_a.o_last;
  assign busy_m    = sel ? bus_b.busy    : bus_a.busy;
  assign o_psum_m  = sel ? bus_b.o_psum  : bus_a.o_psum;

  always @(negedge clk) if (w_ready_m) wr_cnt <= wr_cnt + 1;

  typedef struct packed {
    bit                sel;
    bit                lw;
    bit                sw;
    logic [2:0][7:0]   w;
    logic [7:0][7:0]   x;
    int                n;
    logic [7:0][17:0]  e;
    int                bp;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic send(input bit is_x, input logic [7:0] d);
    int g = 0;
    if (is_x) begin i_valid = 1'b1; i_data = d; end
    else      begin w_valid = 1'b1; w_data = d; end
    while (!(is_x ? i_ready_m : w_ready_m) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check(is_x ? "x_timeout" : "w_timeout", 0, 1);
    @(negedge clk);
    i_valid = 1'b0;
    w_valid = 1'b0;
  endtask

  task automatic run_row(input vec_t v);
    int g, n, wr0;
    sel = v.sel;
    @(negedge clk);
    wr0    = wr_cnt;
    load_w = v.lw;
    if (v.sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    load_w  = 1'b0;
    check("enter_load_w", int'(w_ready_m), int'(v.sw));
    check("enter_load_x", int'(i_ready_m), int'(!v.sw));
    if (v.sw) for (int i = 0; i < 3; i++) send(1'b0, v.w[i]);
    for (int i = 0; i < 8; i++) send(1'b1, v.x[i]);
    n = 1;
    g = 0;
    while (!o_valid_m && g < 50) begin @(negedge clk); n++; g++; end
    check("first_latency", n, 4);
    for (int o = 0; o < v.n; o++) begin
      g = 0;
      while (!o_valid_m && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) check("out_timeout", 0, 1);
      check("psum", int'(o_psum_m), int'(v.e[o]));
      check("last", int'(o_last_m), int'(o == v.n - 1));
      if (o == v.bp) begin
        o_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("bp_valid", int'({o_valid_m, busy_m, i_ready_m, w_ready_m}), 12);
          check("bp_psum", int'(o_psum_m), int'(v.e[o]));
          check("bp_last", int'(o_last_m), 0);
        end
        o_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("busy_drop", int'(busy_m), 0);
    check("idle_out", int'({o_valid_m, o_last_m, o_psum_m}), 0);
    if (!v.sw) check("no_w_ready", wr_cnt - wr0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < 6; r++) tbl[r] = '0;
    tbl[0].lw = 1'b1; tbl[0].sw = 1'b1; tbl[0].n = 4; tbl[0].bp = -1;
    for (int i = 0; i < 3; i++) tbl[0].w[i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) tbl[0].x[i] = 8'(i + 1);
    tbl[0].e[0] = 18'd8;  tbl[0].e[1] = 18'd20; tbl[0].e[2] = 18'd32; tbl[0].e[3] = 18'd44;

    tbl[1].n = 4; tbl[1].bp = -1;
    for (int i = 0; i < 8; i++) tbl[1].x[i] = 8'd1;
    tbl[1].e[0] = 18'd5;  tbl[1].e[1] = 18'd6;  tbl[1].e[2] = 18'd6;  tbl[1].e[3] = 18'd6;

    tbl[2].lw = 1'b1; tbl[2].sw = 1'b1; tbl[2].n = 4; tbl[2].bp = -1;
    for (int i = 0; i < 3; i++) tbl[2].w[i] = 8'hFF;
    for (int i = 0; i < 8; i++) tbl[2].x[i] = 8'h80;
    tbl[2].e[0] = 18'd256; tbl[2].e[1] = 18'd384; tbl[2].e[2] = 18'd384; tbl[2].e[3] = 18'd384;

    tbl[3] = tbl[0]; tbl[3].bp = 1;

    tbl[4] = tbl[0]; tbl[4].sel = 1'b1; tbl[4].n = 8;
    tbl[4].e[0] = 18'd8;  tbl[4].e[1] = 18'd14; tbl[4].e[2] = 18'd20; tbl[4].e[3] = 18'd26;
    tbl[4].e[4] = 18'd32; tbl[4].e[5] = 18'd38; tbl[4].e[6] = 18'd44; tbl[4].e[7] = 18'd23;

    tbl[5] = tbl[0]; tbl[5].lw = 1'b0;

    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; load_w = 1'b0;
    w_valid = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
    w_data = '0; i_data = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_a", int'({w_ready_m, i_ready_m, o_valid_m, o_last_m, busy_m, o_psum_m}), 0);
    sel = 1'b1;
    #0;
    check("reset_outs_b", int'({w_ready_m, i_ready_m, o_valid_m, o_last_m, busy_m, o_psum_m}), 0);
    sel = 1'b0;
    rstn = 1'b1;

    for (int r = 0; r < 5; r++) run_row(tbl[r]);

    // Reset during COMPUTE: partial row is dropped and stored weights are invalidated.
    sel = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    load_w  = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    check("reuse_enter_x", int'(i_ready_m), 1);
    for (int i = 0; i < 8; i++) send(1'b1, 8'(i + 1));
    check("in_compute", int'({busy_m, o_valid_m, i_ready_m}), 4);
    rstn = 1'b0;
    @(negedge clk);
    check("midrow_reset_outs", int'({w_ready_m, i_ready_m, o_valid_m, o_last_m, busy_m, o_psum_m}), 0);
    rstn = 1'b1;
    run_row(tbl[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_row_conv_param.md
Name: pe_row_conv_param

Overview:
- Parametrised 1D convolution row engine: next generation of the fixed 3-tap, stride-2, pad-1 PE row.
- Generalised in data width, kernel size, stride, padding and row length.
- Adds valid/ready handshakes on weight, activation and result streams.
- Adds weight retention across rows.
- Sits between the line buffer and the channel accumulator in the conv front-end. Computes one output row per start.

Parameters:
- WIDTH, 8, signed two's-complement width of weights and activations.
- K, 3, kernel taps. Range 1..8.
- STRIDE, 2, output stride. Range 1..K.
- PAD, 1, zero padding on each row end. Range 0..K-1.
- ROW_LEN, 8, activations per input row. ROW_LEN+2*PAD >= K.
- ACC_WIDTH, 2*WIDTH+$clog2(K), signed accumulator/output width.
- Derived: OUT_LEN = (ROW_LEN+2*PAD-K)/STRIDE+1, using floor division.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to process a row. Sampled only in IDLE.
- load_w  in  1  sampled with start: 1 = reload K weights, 0 = reuse stored weights.
- w_valid  in  1  weight word valid.
- w_data  in  WIDTH  weight word, tap 0 first.
- w_ready  out  1  block accepts weight.
- i_valid  in  1  activation valid.
- i_data  in  WIDTH  activation, index 0 first.
- i_ready  out  1  block accepts activation.
- o_valid  out  1  result valid.
- o_psum  out  ACC_WIDTH  signed output sum.
- o_last  out  1  marks output OUT_LEN-1. Qualified by o_valid.
- o_ready  in  1  downstream accepts result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - rstn low at a clk edge forces IDLE.
  - Clears the weight-valid flag, all counters and the accumulator.
  - All outputs read 0: w_ready, i_ready, o_valid, o_psum, o_last, busy.
  - Applies mid-operation too; any partial row is discarded.
- States: IDLE, LOAD_W, LOAD_X, COMPUTE, OUT.
- IDLE:
  - On start: go to LOAD_W if load_w=1 or weight-valid=0; otherwise go to LOAD_X.
  - start in any other state is ignored.
- LOAD_W:
  - w_ready=1. Each w_valid&&w_ready stores w_data into tap[wc], then wc increments.
  - After tap K-1 is stored: set weight-valid and go to LOAD_X.
- LOAD_X:
  - i_ready=1. Each handshake stores into xbuf[xc].
  - After index ROW_LEN-1 is stored: go to COMPUTE with j=0, k=0, acc=0.
- COMPUTE (one tap per cycle, k=0..K-1):
  - idx = j*STRIDE+k-PAD.
  - If 0<=idx<ROW_LEN: acc += tap[k]*xbuf[idx], signed full-precision product, sign-extended to ACC_WIDTH.
  - Otherwise the term is zero (padding); the cycle is still spent.
  - After k=K-1: go to OUT.
- OUT:
  - o_valid=1, o_psum=acc, o_last=(j==OUT_LEN-1).
  - All three are held stable while o_ready=0.
  - On handshake: if last, go to IDLE; else j++, k=0, acc=0, go to COMPUTE.
- Latency:
  - Last activation handshake at cycle t gives COMPUTE cycles t+1..t+K and first o_valid at t+K+1.
  - With o_ready held at 1, each output takes K+1 cycles.
- Arithmetic:
  - No saturation; ACC_WIDTH guarantees no overflow.
  - o_psum reads 0 whenever o_valid=0.
- Weights persist across rows until reset or a reload.
- w_valid/i_valid outside their load state are ignored (ready=0).

Test Plan:
- Stride-2 row, defaults (K=3, STRIDE=2, PAD=1, ROW_LEN=8):
  - Stimulus: start with load_w=1; weights 1,2,3; activations 1..8; o_ready=1.
  - Response: o_psum sequence 8, 20, 32, 44; o_last on 44 only.
  - Timing: first o_valid 4 cycles after last i handshake; busy drops the cycle after the 44 handshake.
- Stride-1 row:
  - Stimulus: STRIDE=1, same data.
  - Response: outputs 8,14,20,26,32,38,44,23.
- Weight reuse:
  - Stimulus: second start with load_w=0, activations all 1.
  - Response: w_ready never asserts; outputs 5,6,6,6.
- Signed extremes:
  - Stimulus: weights -1,-1,-1; activations all -128.
  - Response: outputs 256,384,384,384.
- Backpressure:
  - Stimulus: o_ready=0 for 5 cycles on output 1.
  - Response: o_valid held; o_psum held at 20; no other state advances; remaining outputs unchanged.
- Reset mid-row:
  - Stimulus: rstn=0 for 1 cycle during COMPUTE; then start with load_w=0.
  - Response: all outputs 0 after the edge; block enters LOAD_W, because weight-valid was cleared.
